// File: rtl/fetch_queue.sv
// fetch_queue: circular buffer of instruction bundles between fetch and decode.
// Fetch pushes whole bundles of up to four instructions. Decode pops one
// instruction per accepted cycle, walking the head bundle with a 2-bit index.
//
// Handshakes:
//  - Push: a bundle is taken when bundleValid_i=1 on a rising edge, no flush is
//    active, and either a slot is free or the head bundle retires on that edge.
//    There is no ready on this side. Fetch must stall on full_o. A bundle
//    offered while the queue is full, with no retirement on that edge, is
//    dropped and overflow_o latches.
//  - Pop: an instruction transfers when instValid_o=1 and instReady_i=1 on a
//    rising edge. While instReady_i=0 the pop outputs hold stable.
module fetch_queue #(
    parameter int addressWidth            = 64,
    parameter int instructionWidth        = 32,
    parameter int bundleSize              = 128,
    parameter int PidSize                 = 32,
    parameter int TidSize                 = 64,
    parameter int instructionCounterWidth = 64,
    parameter int depth                   = 4
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    // push side
    input  logic                               bundleValid_i,
    input  logic [bundleSize-1:0]              bundle_i,
    input  logic [addressWidth-1:0]            bundleAddress_i,
    input  logic [1:0]                         bundleLen_i,
    input  logic [PidSize-1:0]                 bundlePid_i,
    input  logic [TidSize-1:0]                 bundleTid_i,
    input  logic [instructionCounterWidth-1:0] bundleStartMajId_i,
    // control
    input  logic                               flush_i,
    output logic                               full_o,
    output logic                               empty_o,
    output logic                               overflow_o,
    // pop side
    output logic                               instValid_o,
    input  logic                               instReady_i,
    output logic [instructionWidth-1:0]        inst_o,
    output logic [addressWidth-1:0]            instAddress_o,
    output logic [PidSize-1:0]                 instPid_o,
    output logic [TidSize-1:0]                 instTid_o,
    output logic [instructionCounterWidth-1:0] instMajId_o
);

    localparam int PTR_W = $clog2(depth);
    localparam int CNT_W = PTR_W + 1;

    // Slot storage. It has no reset because it is only read while count > 0.
    logic [bundleSize-1:0]              r_bundle [depth];
    logic [addressWidth-1:0]            r_addr   [depth];
    logic [1:0]                         r_len    [depth];
    logic [PidSize-1:0]                 r_pid    [depth];
    logic [TidSize-1:0]                 r_tid    [depth];
    logic [instructionCounterWidth-1:0] r_majid  [depth];

    // Queue bookkeeping.
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic [1:0]       r_idx;
    logic             r_overflow;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_retire;
    logic w_push;
    logic w_drop;
    logic [bundleSize-1:0] w_head_bundle;

    // Handshake decode. A retirement frees the head slot on the same edge, so
    // a push into a full queue can still be accepted.
    always_comb begin
        w_full        = (r_count == CNT_W'(depth));
        w_empty       = (r_count == '0);
        w_pop         = !w_empty && instReady_i;
        w_retire      = w_pop && (r_idx == r_len[r_head]);
        w_push        = bundleValid_i && !flush_i && (!w_full || w_retire);
        w_drop        = bundleValid_i && !flush_i && w_full && !w_retire;
        w_head_bundle = r_bundle[r_head];
    end

    // Pointers, occupancy, head instruction index and sticky overflow.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_idx      <= 2'd0;
            r_overflow <= 1'b0;
        end else if (flush_i) begin
            // Flush discards all contents. It leaves overflow untouched.
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_idx   <= 2'd0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_retire) begin
                r_head <= r_head + 1'b1;
                r_idx  <= 2'd0;
            end else if (w_pop) begin
                r_idx <= r_idx + 2'd1;
            end
            if (w_push && !w_retire) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_retire) begin
                r_count <= r_count - 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Write an accepted bundle into the tail slot.
    always_ff @(posedge clock_i) begin
        if (w_push) begin
            r_bundle[r_tail] <= bundle_i;
            r_addr[r_tail]   <= bundleAddress_i;
            r_len[r_tail]    <= bundleLen_i;
            r_pid[r_tail]    <= bundlePid_i;
            r_tid[r_tail]    <= bundleTid_i;
            r_majid[r_tail]  <= bundleStartMajId_i;
        end
    end

    // Pop outputs are combinational from the head slot at the current index.
    always_comb begin
        instValid_o   = !w_empty;
        inst_o        = w_head_bundle[int'(r_idx) * instructionWidth +: instructionWidth];
        instAddress_o = r_addr[r_head] + addressWidth'({r_idx, 2'b00});
        instPid_o     = r_pid[r_head];
        instTid_o     = r_tid[r_head];
        instMajId_o   = r_majid[r_head] + instructionCounterWidth'(r_idx);
        full_o        = w_full;
        empty_o       = w_empty;
        overflow_o    = r_overflow;
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue. A queue-of-bundles reference model predicts
// every output from the push/pop/flush rules.
module tb_fetch_queue;

    localparam int DEPTH = 4;

    typedef struct {
        logic [127:0] data;
        logic [63:0]  addr;
        logic [1:0]   len;
        logic [31:0]  pid;
        logic [63:0]  tid;
        logic [63:0]  maj;
    } bundle_t;

    logic          clk;
    logic          reset_i;
    logic          bundleValid_i;
    logic [127:0]  bundle_i;
    logic [63:0]   bundleAddress_i;
    logic [1:0]    bundleLen_i;
    logic [31:0]   bundlePid_i;
    logic [63:0]   bundleTid_i;
    logic [63:0]   bundleStartMajId_i;
    logic          flush_i;
    logic          full_o;
    logic          empty_o;
    logic          overflow_o;
    logic          instValid_o;
    logic          instReady_i;
    logic [31:0]   inst_o;
    logic [63:0]   instAddress_o;
    logic [31:0]   instPid_o;
    logic [63:0]   instTid_o;
    logic [63:0]   instMajId_o;

    int checks   = 0;
    int failures = 0;

    // reference model state
    bundle_t mq[$];
    int      m_idx;
    logic    m_ovf;

    logic [259:0] got_v;
    logic [259:0] exp_v;

    fetch_queue dut (
        .clock_i            (clk),
        .reset_i            (reset_i),
        .bundleValid_i      (bundleValid_i),
        .bundle_i           (bundle_i),
        .bundleAddress_i    (bundleAddress_i),
        .bundleLen_i        (bundleLen_i),
        .bundlePid_i        (bundlePid_i),
        .bundleTid_i        (bundleTid_i),
        .bundleStartMajId_i (bundleStartMajId_i),
        .flush_i            (flush_i),
        .full_o             (full_o),
        .empty_o            (empty_o),
        .overflow_o         (overflow_o),
        .instValid_o        (instValid_o),
        .instReady_i        (instReady_i),
        .inst_o             (inst_o),
        .instAddress_o      (instAddress_o),
        .instPid_o          (instPid_o),
        .instTid_o          (instTid_o),
        .instMajId_o        (instMajId_o)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic void model_clear();
        mq.delete();
        m_idx = 0;
    endfunction

    // Apply one rising edge using the inputs currently driven.
    function automatic void model_edge();
        bit      full;
        bit      pop;
        bit      retire;
        bundle_t b;
        if (!reset_i) begin
            model_clear();
            m_ovf = 1'b0;
            return;
        end
        if (flush_i) begin
            model_clear();
            return;
        end
        full   = (mq.size() == DEPTH);
        pop    = (mq.size() > 0) && instReady_i;
        retire = pop && (m_idx == int'(mq[0].len));
        if (retire) begin
            void'(mq.pop_front());
            m_idx = 0;
        end else if (pop) begin
            m_idx++;
        end
        if (bundleValid_i) begin
            if (!full || retire) begin
                b.data = bundle_i;
                b.addr = bundleAddress_i;
                b.len  = bundleLen_i;
                b.pid  = bundlePid_i;
                b.tid  = bundleTid_i;
                b.maj  = bundleStartMajId_i;
                mq.push_back(b);
            end else begin
                m_ovf = 1'b1;
            end
        end
    endfunction

    // Expected {valid, full, empty, overflow, inst, addr, pid, tid, majid}.
    // The data fields are zero when nothing is held.
    function automatic logic [259:0] exp_vec();
        logic [255:0] d;
        bundle_t      b;
        d = '0;
        if (mq.size() > 0) begin
            b = mq[0];
            d = {b.data[m_idx*32 +: 32], b.addr + 64'(4 * m_idx), b.pid, b.tid,
                 b.maj + 64'(m_idx)};
        end
        return {1'(mq.size() > 0), 1'(mq.size() == DEPTH), 1'(mq.size() == 0), m_ovf, d};
    endfunction

    // Observed outputs in the same layout as exp_vec.
    function automatic logic [259:0] obs_vec();
        logic [255:0] d;
        d = instValid_o ? {inst_o, instAddress_o, instPid_o, instTid_o, instMajId_o} : '0;
        return {instValid_o, full_o, empty_o, overflow_o, d};
    endfunction

    // ---------------- driver tasks ----------------
    // Inputs change after the falling edge. The model advances on the rising edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic set_push(input logic v, input logic [63:0] a, input logic [1:0] l,
                            input logic [63:0] m);
        bundleValid_i      = v;
        bundle_i           = {$urandom, $urandom, $urandom, $urandom};
        bundleAddress_i    = a;
        bundleLen_i        = l;
        bundlePid_i        = $urandom;
        bundleTid_i        = {$urandom, $urandom};
        bundleStartMajId_i = m;
    endtask

    task automatic do_reset();
        set_push(1'b0, 64'd0, 2'd0, 64'd0);
        flush_i     = 1'b0;
        instReady_i = 1'b0;
        reset_i     = 1'b0;
        tick();
        reset_i = 1'b1;
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_i = 1'b0;
        set_push(1'b0, 64'd0, 2'd0, 64'd0);
        flush_i     = 1'b0;
        instReady_i = 1'b0;
        model_clear();
        m_ovf = 1'b0;
        #1;
        checks++;
        if (instValid_o !== 1'b0 || full_o !== 1'b0 || empty_o !== 1'b1 || overflow_o !== 1'b0) begin
            $display("FAIL reset_flags got=%b%b%b%b exp=0010", instValid_o, full_o, empty_o, overflow_o);
            failures++;
        end
        @(negedge clk);
        reset_i = 1'b1;
        tick();
        got_v = obs_vec(); exp_v = exp_vec(); checks++;
        if (got_v !== exp_v) begin
            $display("FAIL reset_release got=%h exp=%h", got_v, exp_v);
            failures++;
        end
    endtask

    task automatic test_single();
        do_reset();
        instReady_i = 1'b1;
        set_push(1'b1, 64'h1000, 2'd3, 64'd10);
        tick();
        set_push(1'b0, 64'd0, 2'd0, 64'd0);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (instValid_o !== 1'b1 || instAddress_o !== 64'h1000 + 64'(4 * k) ||
                instMajId_o !== 64'(10 + k)) begin
                $display("FAIL single_k%0d got=%b/%h/%0d exp=1/%h/%0d", k, instValid_o,
                         instAddress_o, instMajId_o, 64'h1000 + 64'(4 * k), 10 + k);
                failures++;
            end
            got_v = obs_vec(); exp_v = exp_vec(); checks++;
            if (got_v !== exp_v) begin
                $display("FAIL single_model_k%0d got=%h exp=%h", k, got_v, exp_v);
                failures++;
            end
            tick();
        end
        checks++;
        if (instValid_o !== 1'b0 || empty_o !== 1'b1) begin
            $display("FAIL single_drained got=%b%b exp=01", instValid_o, empty_o);
            failures++;
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int b = 0; b < 4; b++) begin
            set_push(1'b1, {$urandom, $urandom}, 2'($urandom_range(0, 3)), {$urandom, $urandom});
            tick();
            got_v = obs_vec(); exp_v = exp_vec(); checks++;
            if (got_v !== exp_v) begin
                $display("FAIL fill_%0d got=%h exp=%h", b, got_v, exp_v);
                failures++;
            end
        end
        checks++;
        if (full_o !== 1'b1 || overflow_o !== 1'b0) begin
            $display("FAIL full_flag got=%b%b exp=10", full_o, overflow_o);
            failures++;
        end
        set_push(1'b1, 64'hDEAD_0000, 2'd1, 64'd99);
        tick();
        set_push(1'b0, 64'd0, 2'd0, 64'd0);
        checks++;
        if (overflow_o !== 1'b1 || full_o !== 1'b1) begin
            $display("FAIL overflow_set got=%b%b exp=11", overflow_o, full_o);
            failures++;
        end
        instReady_i = 1'b1;
        for (int c = 0; c < 18; c++) begin
            got_v = obs_vec(); exp_v = exp_vec(); checks++;
            if (got_v !== exp_v) begin
                $display("FAIL drain_c%0d got=%h exp=%h", c, got_v, exp_v);
                failures++;
            end
            tick();
        end
        checks++;
        if (empty_o !== 1'b1 || overflow_o !== 1'b1) begin
            $display("FAIL drain_end got=%b%b exp=11", empty_o, overflow_o);
            failures++;
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int b = 0; b < 4; b++) begin
            set_push(1'b1, 64'(b * 64), 2'd0, 64'(b));
            tick();
        end
        set_push(1'b1, 64'h8000, 2'd2, 64'd50);
        instReady_i = 1'b1;
        tick();
        set_push(1'b0, 64'd0, 2'd0, 64'd0);
        instReady_i = 1'b0;
        checks++;
        if (full_o !== 1'b1 || overflow_o !== 1'b0 || instAddress_o !== 64'd64) begin
            $display("FAIL full_pushpop got=%b%b/%h exp=10/40", full_o, overflow_o, instAddress_o);
            failures++;
        end
        got_v = obs_vec(); exp_v = exp_vec(); checks++;
        if (got_v !== exp_v) begin
            $display("FAIL full_pushpop_model got=%h exp=%h", got_v, exp_v);
            failures++;
        end
        instReady_i = 1'b1;
        for (int c = 0; c < 7; c++) begin
            tick();
            got_v = obs_vec(); exp_v = exp_vec(); checks++;
            if (got_v !== exp_v) begin
                $display("FAIL full_pushpop_drain%0d got=%h exp=%h", c, got_v, exp_v);
                failures++;
            end
        end
    endtask

    task automatic test_wrap();
        logic [63:0] exp_a [5];
        exp_a[0] = 64'hFFFF_FFFF_FFFF_FFFC;
        exp_a[1] = 64'h0;
        exp_a[2] = 64'h4;
        exp_a[3] = 64'hFFFF_FFFF_FFFF_FFF8;
        exp_a[4] = 64'hFFFF_FFFF_FFFF_FFFC;
        do_reset();
        instReady_i = 1'b1;
        set_push(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        set_push(1'b1, 64'h0, 2'd1, 64'd5);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (instValid_o !== 1'b1 || instAddress_o !== exp_a[c]) begin
                $display("FAIL wrap_addr%0d got=%b/%h exp=1/%h", c, instValid_o, instAddress_o, exp_a[c]);
                failures++;
            end
            got_v = obs_vec(); exp_v = exp_vec(); checks++;
            if (got_v !== exp_v) begin
                $display("FAIL wrap_model%0d got=%h exp=%h", c, got_v, exp_v);
                failures++;
            end
            tick();
            if (c == 1) set_push(1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 2'd3, 64'd7);
            else set_push(1'b0, 64'd0, 2'd0, 64'd0);
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int b = 0; b < 3; b++) begin
            set_push(1'b1, {$urandom, $urandom}, 2'($urandom_range(0, 3)), 64'(b));
            tick();
        end
        set_push(1'b1, 64'h1234, 2'd0, 64'd1);
        flush_i     = 1'b1;
        instReady_i = 1'b1;
        tick();
        flush_i = 1'b0;
        set_push(1'b0, 64'd0, 2'd0, 64'd0);
        checks++;
        if (empty_o !== 1'b1 || instValid_o !== 1'b0 || full_o !== 1'b0) begin
            $display("FAIL flush got=%b%b%b exp=100", empty_o, instValid_o, full_o);
            failures++;
        end
        tick();
        got_v = obs_vec(); exp_v = exp_vec(); checks++;
        if (got_v !== exp_v) begin
            $display("FAIL flush_after got=%h exp=%h", got_v, exp_v);
            failures++;
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int b = 0; b < 2; b++) begin
            set_push(1'b1, 64'(32'h2000 + b * 16), 2'd3, 64'(b));
            tick();
        end
        set_push(1'b0, 64'd0, 2'd0, 64'd0);
        #2;
        reset_i = 1'b0;
        model_clear();
        m_ovf = 1'b0;
        #1;
        checks++;
        if (instValid_o !== 1'b0 || full_o !== 1'b0 || empty_o !== 1'b1 || overflow_o !== 1'b0) begin
            $display("FAIL async_reset got=%b%b%b%b exp=0010", instValid_o, full_o, empty_o, overflow_o);
            failures++;
        end
        @(negedge clk);
        reset_i = 1'b1;
        instReady_i = 1'b1;
        set_push(1'b1, 64'h3000, 2'd1, 64'd40);
        tick();
        set_push(1'b0, 64'd0, 2'd0, 64'd0);
        checks++;
        if (instValid_o !== 1'b1 || instAddress_o !== 64'h3000 || instMajId_o !== 64'd40) begin
            $display("FAIL async_first got=%b/%h/%0d exp=1/3000/40", instValid_o, instAddress_o, instMajId_o);
            failures++;
        end
        for (int c = 0; c < 3; c++) begin
            got_v = obs_vec(); exp_v = exp_vec(); checks++;
            if (got_v !== exp_v) begin
                $display("FAIL async_model%0d got=%h exp=%h", c, got_v, exp_v);
                failures++;
            end
            tick();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 500; c++) begin
            set_push(1'($urandom_range(0, 99) < 60), {$urandom, $urandom}, 2'($urandom_range(0, 3)),
                     {$urandom, $urandom});
            instReady_i = 1'($urandom_range(0, 99) < 55);
            flush_i     = 1'($urandom_range(0, 99) < 3);
            tick();
            got_v = obs_vec(); exp_v = exp_vec(); checks++;
            if (got_v !== exp_v) begin
                $display("FAIL random_c%0d got=%h exp=%h", c, got_v, exp_v);
                failures++;
            end
        end
        flush_i = 1'b0;
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_full_push_pop();
        test_wrap();
        test_flush();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameters SHALL be: addressWidth 64, fetched address width; instructionWidth 32, instruction width; bundleSize 128, bundle width of 4 instructions; PidSize 32, process ID width; TidSize 64, thread ID width; instructionCounterWidth 64, major ID width; depth 4, bundle slots (power of two, at least 2).
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 Clock and reset ports SHALL be: clock_i, in, 1, rising-edge clock; reset_i, in, 1, asynchronous active-low reset.
REQ-004 Push ports SHALL be: bundleValid_i, in, 1, bundle present; bundle_i, in, bundleSize, instruction 0 at bits [0:31]; bundleAddress_i, in, addressWidth, address of instruction 0; bundleLen_i, in, 2, valid instructions minus one; bundlePid_i, in, PidSize; bundleTid_i, in, TidSize; bundleStartMajId_i, in, instructionCounterWidth, major ID of instruction 0.
REQ-005 Control ports SHALL be: flush_i, in, 1, discard all contents; full_o, out, 1, no free slot (drives fetch stall); empty_o, out, 1, no instruction held; overflow_o, out, 1, sticky push-while-full error.
REQ-006 Pop ports SHALL be: instValid_o, out, 1, instruction available; instReady_i, in, 1, decoder accepts; inst_o, out, instructionWidth; instAddress_o, out, addressWidth; instPid_o, out, PidSize; instTid_o, out, TidSize; instMajId_o, out, instructionCounterWidth.

Function
REQ-007 Storage SHALL be a circular buffer of depth bundle slots with head pointer, tail pointer, occupancy count (0..depth) and 2-bit head instruction index.
REQ-008 A push SHALL occur on a rising edge with bundleValid_i=1, flush_i=0 and count<depth; it writes all bundle fields into the tail slot, advances tail modulo depth and increments count.
REQ-009 bundleValid_i=1 with count==depth and no same-cycle bundle retirement SHALL drop the bundle, leave state unchanged and set overflow_o until reset.
REQ-010 A push SHALL be accepted while full if the same edge retires the head bundle; count stays depth.
REQ-011 instValid_o SHALL be 1 iff count>0; pop outputs are combinational from the head slot at index i.
REQ-012 inst_o SHALL equal bits [32*i : 32*i+31] of the head bundle.
REQ-013 instAddress_o SHALL equal head address + 4*i, modulo 2^addressWidth.
REQ-014 instMajId_o SHALL equal head start major ID + i, modulo 2^instructionCounterWidth; instPid_o and instTid_o SHALL be the head slot values.
REQ-015 A pop SHALL occur on an edge with instValid_o=1 and instReady_i=1.
REQ-016 On a pop with i<stored len, i SHALL increment.
REQ-017 On a pop with i==stored len, the head bundle SHALL retire: head advances modulo depth, i returns to 0, count decrements unless a push is accepted on the same edge.
REQ-018 Push-to-pop latency SHALL be 1 cycle: a bundle pushed into an empty queue is visible on instValid_o in the following cycle; no same-cycle bypass.
REQ-019 With instReady_i=0, all pop outputs SHALL hold stable.
REQ-020 full_o SHALL equal (count==depth) and empty_o SHALL equal (count==0), both from registered state.
REQ-021 flush_i=1 SHALL on that edge zero head, tail, count and i, and ignore any same-cycle push or pop; overflow_o is unaffected.
REQ-022 The 2-bit len field SHALL encode 0..3 as 1..4 instructions; instructions beyond len SHALL never be output.

Reset
REQ-023 reset_i=0 SHALL immediately, without a clock edge, zero head, tail, count, i and overflow_o.
REQ-024 During reset: instValid_o=0, full_o=0, empty_o=1, overflow_o=0.
REQ-025 Slot data SHALL need no reset; pop data outputs are don't-care while instValid_o=0.
REQ-026 Reset asserted mid-operation SHALL discard all contents; the first edge after deassertion behaves as an empty queue.

Verification
REQ-027 Push one bundle, address 0x1000, len 3, start major ID 10, instReady_i=1 held -> next 4 cycles output addresses 0x1000/0x1004/0x1008/0x100C with major IDs 10..13, then instValid_o=0.
REQ-028 Push 4 bundles with instReady_i=0 -> full_o=1; a 5th push sets overflow_o=1 and after draining the 4 original bundles are output in order.
REQ-029 Full queue, head at last instruction, push and pop on the same edge -> push accepted, full_o stays 1, overflow_o stays 0.
REQ-030 Bundle len 0 at address 0xFFFF_FFFF_FFFF_FFFC followed by bundle len 1 -> single instruction, then addresses wrap to 0x0 and 0x4 per the pushed address.
REQ-031 Queue holding 3 bundles, flush_i together with bundleValid_i -> next cycle empty_o=1, instValid_o=0, pushed bundle not stored.
REQ-032 Assert reset_i low asynchronously between edges with 2 bundles held -> outputs immediately at reset values; first push after release is output with i=0.
